cnn_sdiv_20s_6u_seq: RTL
========================

Name: cnn_sdiv_20s_6u_seq

Overview:
- Sequential divider that inverts the signed-14 × unsigned-6 product path of the conv1 fixed-point datapath.
- Divides a signed 20-bit value by an unsigned 6-bit value and returns a signed 14-bit quotient and a signed remainder.
- Used for requantisation and average scaling after conv1 accumulation. Produces one quotient bit per cycle using restoring division.
- Uses valid/ready handshakes on both input and output.

Parameters:
- DIVIDEND_WIDTH, 20, width of the signed dividend.
- DIVISOR_WIDTH, 6, width of the unsigned divisor.
- QUOTIENT_WIDTH, 14, width of the signed quotient; the result saturates to this range.

Ports:
- ap_clk  in  1  clock; all state changes on its rising edge.
- ap_rst_n  in  1  asynchronous reset, active-low.
- in_valid  in  1  dividend and divisor are valid.
- in_ready  out  1  block can accept an operation.
- dividend  in  DIVIDEND_WIDTH  signed dividend.
- divisor  in  DIVISOR_WIDTH  unsigned divisor.
- out_valid  out  1  result registers hold a valid result.
- out_ready  in  1  downstream accepts the result.
- quotient  out  QUOTIENT_WIDTH  signed quotient, truncated toward zero, saturated.
- remainder  out  DIVISOR_WIDTH+1  signed remainder; its sign follows the dividend.
- ovf  out  1  quotient was saturated because of range overflow.
- div_by_zero  out  1  divisor was 0.

Behaviour:
- Reset (ap_rst_n low, asynchronous):
  - state goes to IDLE.
  - in_ready=0 while reset is asserted and 1 after release.
  - out_valid=0, quotient=0, remainder=0, ovf=0, div_by_zero=0.
  - Internal shift, accumulator and counter registers clear to 0.
  - Any reset mid-operation abandons the operation silently.
- States:
  - IDLE → CALC when in_valid & in_ready. in_ready = (state==IDLE).
  - CALC runs DIVIDEND_WIDTH iterations, counter from DIVIDEND_WIDTH-1 down to 0. It goes to FIX after the iteration with counter=0.
  - FIX lasts one cycle: applies signs, saturation and flags, registers the outputs and sets out_valid. It always goes to DONE.
  - DONE holds the outputs stable while out_ready=0. On out_valid & out_ready it clears out_valid and goes to IDLE.
- Accept edge T:
  - Latch |dividend| as an unsigned DIVIDEND_WIDTH value; -2^19 maps to 2^19 with no overflow.
  - Latch the dividend sign, the divisor, and the divide-by-zero flag (divisor==0).
- Iterations, edges T+1..T+20:
  - Shift the partial remainder left, taking the next dividend magnitude bit, MSB first.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore it and set the bit to 0.
  - The partial remainder is DIVISOR_WIDTH+1 bits wide.
  - Latency is uniform for all operands, including divide-by-zero.
- Edge T+21 (FIX):
  - Apply the sign: q = sign ? -|q| : |q|, and r = sign ? -|r| : |r|.
  - Saturation: if q > 8191, output 8191 with ovf=1. If q < -8192, output -8192 with ovf=1. The remainder stays the true remainder.
  - Divide by zero: quotient = dividend<0 ? -8192 : 8191, remainder=0, div_by_zero=1, ovf=0.
  - out_valid is high from T+21.
- Throughput:
  - One operation per 23 cycles minimum (accept, 20 CALC, FIX, DONE handshake, IDLE).
  - in_valid is ignored outside IDLE. Operands do not need to be held after the accept edge.
- Stability: outputs change only on the FIX edge and on reset. They are held after the DONE handshake until the next FIX.
- Simultaneity:
  - in_valid while in DONE is not accepted; it waits for IDLE.
  - A reset edge overrides every other event in the same cycle.

Test Plan:
- 1000/7 → quotient 142, remainder 6, flags 0. -1000/7 → quotient -142, remainder -6. out_valid rises exactly 21 edges after the accept edge.
- -524288/63 → true quotient -8322, so quotient=-8192, ovf=1, remainder=-2. 516033/63 → quotient 8191, remainder 0, ovf=0 (boundary, no saturation).
- 500/0 → quotient 8191, remainder 0, div_by_zero=1. -5/0 → quotient -8192, div_by_zero=1. Latency is still 21.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid.
  - quotient, remainder and flags stay stable and in_ready=0.
  - A pulse of in_valid with 7/1 is not accepted and does not corrupt the result.
  - Raising out_ready completes the handshake, and in_ready=1 on the following cycle.
- Reset asserted on the 10th CALC cycle of 12345/9:
  - All outputs go to 0 immediately (asynchronous).
  - After release, in_ready=1 and a new operation 12345/9 yields quotient 1371, remainder 6.
- Back-to-back randomized sequence of 200 operations with random out_ready:
  - Every result matches the truncating signed-division reference model with saturation rules.
  - No result is lost or duplicated.

Source files
------------

// File: rtl/cnn_sdiv_20s_6u_seq.sv
// cnn_sdiv_20s_6u_seq
//   Sequential restoring divider for conv1 requantisation / average scaling.
//   Divides a signed DIVIDEND_WIDTH value by an unsigned DIVISOR_WIDTH value,
//   one quotient bit per cycle, and returns a saturated signed quotient and a
//   signed remainder whose sign follows the dividend.
//
//   Ports
//     ap_clk, ap_rst_n        clock, async active-low reset
//     in_valid / in_ready     operand handshake (dividend, divisor)
//     out_valid / out_ready   result handshake (quotient, remainder, ovf, div_by_zero)
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for operands, in_ready high
//   CALC   | one restoring iteration per cycle, cnt_q counts down to 0
//   FIX    | apply sign, saturation and flags; register outputs
//   DONE   | result held with out_valid high until out_ready

module cnn_sdiv_20s_6u_seq #(
   parameter int DIVIDEND_WIDTH = 20,
   parameter int DIVISOR_WIDTH  = 6,
   parameter int QUOTIENT_WIDTH = 14
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DIVIDEND_WIDTH-1:0] dividend,
   input  logic [DIVISOR_WIDTH-1:0]  divisor,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [QUOTIENT_WIDTH-1:0] quotient,
   output logic [DIVISOR_WIDTH:0]    remainder,
   output logic                      ovf,
   output logic                      div_by_zero
);

   localparam int DW = DIVIDEND_WIDTH;
   localparam int VW = DIVISOR_WIDTH;
   localparam int QW = QUOTIENT_WIDTH;
   localparam int RW = DIVISOR_WIDTH + 1;
   localparam int CW = $clog2(DIVIDEND_WIDTH);

   // Largest positive quotient and magnitude of the most negative quotient.
   localparam logic [DW-1:0] Q_POS_MAG = DW'((64'd1 << (QW-1)) - 64'd1);
   localparam logic [DW-1:0] Q_NEG_MAG = DW'(64'd1 << (QW-1));
   localparam logic [QW-1:0] Q_SAT_POS = {1'b0, {(QW-1){1'b1}}};
   localparam logic [QW-1:0] Q_SAT_NEG = {1'b1, {(QW-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [DW-1:0]   mag_q, mag_d;
   logic [DW-1:0]   quo_q, quo_d;
   logic [RW-1:0]   rem_q, rem_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [VW-1:0]   dvs_q, dvs_d;
   logic            sign_q, sign_d;
   logic            dbz_q, dbz_d;
   logic [QW-1:0]   quotient_q, quotient_d;
   logic [RW-1:0]   remainder_q, remainder_d;
   logic            ovf_q, ovf_d;
   logic            div_by_zero_q, div_by_zero_d;
   logic            out_valid_q, out_valid_d;

   logic [RW-1:0]   shifted;
   logic [RW:0]     diff;
   logic [DW-1:0]   dividend_abs;
   logic [DW-1:0]   quo_neg;
   logic [RW-1:0]   rem_neg;

   // The partial remainder stays below the divisor, so its MSB is always 0
   // before the shift and the shifted value fits in RW bits.
   assign shifted      = {rem_q[RW-2:0], mag_q[DW-1]};
   assign diff         = {1'b0, shifted} - {2'b00, dvs_q};
   // Two's-complement negate in DW bits maps -2^(DW-1) onto 2^(DW-1) unsigned.
   assign dividend_abs = dividend[DW-1] ? (~dividend + 1'b1) : dividend;
   assign quo_neg      = ~quo_q + 1'b1;
   assign rem_neg      = ~rem_q + 1'b1;

   always_comb begin
      state_d       = state_q;
      mag_d         = mag_q;
      quo_d         = quo_q;
      rem_d         = rem_q;
      cnt_d         = cnt_q;
      dvs_d         = dvs_q;
      sign_d        = sign_q;
      dbz_d         = dbz_q;
      quotient_d    = quotient_q;
      remainder_d   = remainder_q;
      ovf_d         = ovf_q;
      div_by_zero_d = div_by_zero_q;
      out_valid_d   = out_valid_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_CALC;
               mag_d   = dividend_abs;
               sign_d  = dividend[DW-1];
               dvs_d   = divisor;
               dbz_d   = (divisor == '0);
               quo_d   = '0;
               rem_d   = '0;
               cnt_d   = CW'(DW-1);
            end
         end

         S_CALC: begin
            mag_d = {mag_q[DW-2:0], 1'b0};
            // diff[RW] is the borrow: set means restore the shifted value.
            rem_d = diff[RW] ? shifted : diff[RW-1:0];
            quo_d = {quo_q[DW-2:0], ~diff[RW]};
            if (cnt_q == '0) begin
               state_d = S_FIX;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         S_FIX: begin
            state_d       = S_DONE;
            out_valid_d   = 1'b1;
            ovf_d         = 1'b0;
            div_by_zero_d = dbz_q;
            if (dbz_q) begin
               quotient_d  = sign_q ? Q_SAT_NEG : Q_SAT_POS;
               remainder_d = '0;
            end else begin
               remainder_d = sign_q ? rem_neg : rem_q;
               if (sign_q) begin
                  if (quo_q > Q_NEG_MAG) begin
                     quotient_d = Q_SAT_NEG;
                     ovf_d      = 1'b1;
                  end else begin
                     quotient_d = quo_neg[QW-1:0];
                  end
               end else begin
                  if (quo_q > Q_POS_MAG) begin
                     quotient_d = Q_SAT_POS;
                     ovf_d      = 1'b1;
                  end else begin
                     quotient_d = quo_q[QW-1:0];
                  end
               end
            end
         end

         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q       <= S_IDLE;
         mag_q         <= '0;
         quo_q         <= '0;
         rem_q         <= '0;
         cnt_q         <= '0;
         dvs_q         <= '0;
         sign_q        <= 1'b0;
         dbz_q         <= 1'b0;
         quotient_q    <= '0;
         remainder_q   <= '0;
         ovf_q         <= 1'b0;
         div_by_zero_q <= 1'b0;
         out_valid_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         mag_q         <= mag_d;
         quo_q         <= quo_d;
         rem_q         <= rem_d;
         cnt_q         <= cnt_d;
         dvs_q         <= dvs_d;
         sign_q        <= sign_d;
         dbz_q         <= dbz_d;
         quotient_q    <= quotient_d;
         remainder_q   <= remainder_d;
         ovf_q         <= ovf_d;
         div_by_zero_q <= div_by_zero_d;
         out_valid_q   <= out_valid_d;
      end
   end

   // Gated by the reset pin so in_ready is low for the whole reset window.
   assign in_ready    = ap_rst_n & (state_q == S_IDLE);
   assign out_valid   = out_valid_q;
   assign quotient    = quotient_q;
   assign remainder   = remainder_q;
   assign ovf         = ovf_q;
   assign div_by_zero = div_by_zero_q;

endmodule
